sram_arbiter: RTL and testbench

Two-master Wishbone arbiter that shares the single pipelined SRAM controller port between the ZipCPU data bus (master A) and the debug/host bus (master B). It grants one master at a time for the full duration of its bus cycle and routes acks back to that master only. It counts outstanding requests so the slave is never handed over mid-transaction. It sits between the bus interconnect and the SRAM controller; the slave side connects directly to the controller's Wishbone inputs.

---
 rtl/sram_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_sram_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : sram_arbiter                                                      |
// | Desc    : Two-master Wishbone arbiter in front of the pipelined SRAM        |
// |           controller. Define SRAMARB_TIMEOUT_EN to enable the ack watchdog. |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module sram_arbiter #(
  parameter int AW      = 16,
  parameter int CW      = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_a_cyc,
  input  logic          i_a_stb,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [31:0]   i_a_data,
  input  logic [3:0]    i_a_sel,
  output logic          o_a_ack,
  output logic          o_a_stall,
  output logic          o_a_err,
  input  logic          i_b_cyc,
  input  logic          i_b_stb,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [31:0]   i_b_data,
  input  logic [3:0]    i_b_sel,
  output logic          o_b_ack,
  output logic          o_b_stall,
  output logic          o_b_err,
  output logic [31:0]   o_rdata,
  output logic          o_cyc,
  output logic          o_stb,
  output logic          o_we,
  output logic [AW-1:0] o_addr,
  output logic [31:0]   o_data,
  output logic [3:0]    o_sel,
  input  logic          i_ack,
  input  logic          i_stall,
  input  logic [31:0]   i_rdata
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT_A = 2'd1,
    S_GRANT_B = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  localparam logic [CW-1:0] C_COUNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] C_COUNT_ONE = CW'(1);

  state_t        r_state;
  logic          r_last_b;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          w_full;
  logic          w_ack_ok;
  logic          w_accept;
  logic          w_own_cyc;
  logic          w_timeout;

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("sram_arbiter: TIMEOUT must be at least 1");
  end

  assign w_full   = (r_count == C_COUNT_MAX);
  // Acks with nothing outstanding are stray and must not reach a master.
  assign w_ack_ok = i_ack && (r_count != '0);
  assign o_rdata  = i_rdata;

  always_comb begin
    o_cyc     = 1'b0;
    o_stb     = 1'b0;
    o_we      = 1'b0;
    o_addr    = '0;
    o_data    = '0;
    o_sel     = '0;
    o_a_ack   = 1'b0;
    o_b_ack   = 1'b0;
    o_a_stall = 1'b1;
    o_b_stall = 1'b1;
    w_own_cyc = 1'b0;
    case (r_state)
      S_GRANT_A: begin
        o_cyc     = i_a_cyc;
        o_stb     = i_a_stb && !w_full;
        o_we      = i_a_we;
        o_addr    = i_a_addr;
        o_data    = i_a_data;
        o_sel     = i_a_sel;
        o_a_stall = i_stall || w_full;
        o_a_ack   = w_ack_ok;
        w_own_cyc = i_a_cyc;
      end
      S_GRANT_B: begin
        o_cyc     = i_b_cyc;
        o_stb     = i_b_stb && !w_full;
        o_we      = i_b_we;
        o_addr    = i_b_addr;
        o_data    = i_b_data;
        o_sel     = i_b_sel;
        o_b_stall = i_stall || w_full;
        o_b_ack   = w_ack_ok;
        w_own_cyc = i_b_cyc;
      end
      default: begin
      end
    endcase
  end

  assign w_accept = o_stb && !i_stall;

  always_comb begin
    w_count_next = r_count;
    case ({w_accept, w_ack_ok})
      2'b10:   w_count_next = r_count + C_COUNT_ONE;
      2'b01:   w_count_next = r_count - C_COUNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

`ifdef SRAMARB_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] C_TIMEOUT = WDW'(TIMEOUT);
  localparam logic [WDW-1:0] C_WDOG_ONE = WDW'(1);

  logic [WDW-1:0] r_wdog;

  assign w_timeout = (r_wdog == C_TIMEOUT);
  assign o_a_err   = w_timeout && (r_state == S_GRANT_A);
  assign o_b_err   = w_timeout && (r_state == S_GRANT_B);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wdog <= '0;
    end else if ((r_state != S_IDLE) && (r_count != '0) && !i_ack && !w_timeout) begin
      r_wdog <= r_wdog + C_WDOG_ONE;
    end else begin
      r_wdog <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign o_a_err   = 1'b0;
  assign o_b_err   = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_last_b <= 1'b1;
    end else if (w_timeout) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
      case (r_state)
        S_IDLE: begin
          // On a tie the master that did not own the bus last wins.
          if (i_a_cyc && (!i_b_cyc || r_last_b)) begin
            r_state  <= S_GRANT_A;
            r_last_b <= 1'b0;
          end else if (i_b_cyc) begin
            r_state  <= S_GRANT_B;
            r_last_b <= 1'b1;
          end
        end
        S_GRANT_A, S_GRANT_B: begin
          if (!w_own_cyc) begin
            r_state <= (w_count_next == '0) ? S_IDLE : S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_count_next == '0) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// Directed, table-driven bench for sram_arbiter built with a 2-bit outstanding counter.
module tb_sram_arbiter;

  localparam int AW = 16;
  localparam int CW = 2;
  localparam logic [15:0] AA = 16'h0123;
  localparam logic [15:0] BA = 16'hB0B0;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_a_cyc = 1'b0, i_a_stb = 1'b0, i_a_we = 1'b0;
  logic [AW-1:0] i_a_addr = AA;
  logic [31:0]   i_a_data = 32'h1111_2222;
  logic [3:0]    i_a_sel = 4'hF;
  logic          i_b_cyc = 1'b0, i_b_stb = 1'b0, i_b_we = 1'b1;
  logic [AW-1:0] i_b_addr = BA;
  logic [31:0]   i_b_data = 32'hCAFE_F00D;
  logic [3:0]    i_b_sel = 4'h3;
  logic          i_ack = 1'b0, i_stall = 1'b0;
  logic [31:0]   i_rdata = 32'hDEAD_BEEF;
  logic          o_a_ack, o_a_stall, o_a_err, o_b_ack, o_b_stall, o_b_err;
  logic [31:0]   o_rdata, o_data;
  logic          o_cyc, o_stb, o_we;
  logic [AW-1:0] o_addr;
  logic [3:0]    o_sel;

  sram_arbiter #(.AW(AW), .CW(CW), .TIMEOUT(255)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_a_cyc(i_a_cyc), .i_a_stb(i_a_stb), .i_a_we(i_a_we), .i_a_addr(i_a_addr),
    .i_a_data(i_a_data), .i_a_sel(i_a_sel),
    .o_a_ack(o_a_ack), .o_a_stall(o_a_stall), .o_a_err(o_a_err),
    .i_b_cyc(i_b_cyc), .i_b_stb(i_b_stb), .i_b_we(i_b_we), .i_b_addr(i_b_addr),
    .i_b_data(i_b_data), .i_b_sel(i_b_sel),
    .o_b_ack(o_b_ack), .o_b_stall(o_b_stall), .o_b_err(o_b_err),
    .o_rdata(o_rdata), .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we),
    .o_addr(o_addr), .o_data(o_data), .o_sel(o_sel),
    .i_ack(i_ack), .i_stall(i_stall), .i_rdata(i_rdata)
  );

  always #5 i_clk = ~i_clk;

  // in  = {a_cyc, a_stb, b_cyc, b_stb, ack, stall}
  // exp = {cyc, stb, a_ack, a_stall, b_ack, b_stall}
  typedef struct packed {
    logic [5:0]  in;
    logic [5:0]  exp;
    logic [15:0] addr;
  } vec_t;

  vec_t vecs[$];
  int tests = 0;
  int fails = 0;

  task automatic add(input logic [5:0] in, input logic [5:0] exp, input logic [15:0] addr);
    vec_t v;
    v.in = in;
    v.exp = exp;
    v.addr = addr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [5:0] outs();
    return {o_cyc, o_stb, o_a_ack, o_a_stall, o_b_ack, o_b_stall};
  endfunction

  initial begin
    // Tie from reset: A first, B two cycles after A releases, then A again.
    add(6'b000000, 6'b000101, 16'h0);
    add(6'b101000, 6'b000101, 16'h0);
    add(6'b101000, 6'b100001, AA);
    add(6'b001000, 6'b000001, AA);
    add(6'b001000, 6'b000101, 16'h0);
    add(6'b001000, 6'b100100, BA);
    add(6'b101000, 6'b100100, BA);
    add(6'b100000, 6'b000100, BA);
    add(6'b101000, 6'b000101, 16'h0);
    add(6'b101000, 6'b100001, AA);
    add(6'b000000, 6'b000001, AA);
    add(6'b000000, 6'b000101, 16'h0);
    // A single read, ack three cycles after the strobe is taken.
    add(6'b110000, 6'b000101, 16'h0);
    add(6'b110000, 6'b110001, AA);
    add(6'b100000, 6'b100001, AA);
    add(6'b100000, 6'b100001, AA);
    add(6'b100010, 6'b101001, AA);
    add(6'b000000, 6'b000001, AA);
    add(6'b000000, 6'b000101, 16'h0);
    // B burst of four writes while A waits; then A leaves with two outstanding.
    add(6'b111100, 6'b000101, 16'h0);
    add(6'b111100, 6'b110100, BA);
    add(6'b111110, 6'b110110, BA);
    add(6'b111110, 6'b110110, BA);
    add(6'b111110, 6'b110110, BA);
    add(6'b111010, 6'b100110, BA);
    add(6'b110000, 6'b000100, BA);
    add(6'b110000, 6'b000101, 16'h0);
    add(6'b110000, 6'b110001, AA);
    add(6'b110000, 6'b110001, AA);
    add(6'b000000, 6'b000001, AA);
    add(6'b000010, 6'b000101, 16'h0);
    add(6'b000010, 6'b000101, 16'h0);
    add(6'b000000, 6'b000101, 16'h0);
    // Saturation at three outstanding, slave stall, drain of three.
    add(6'b110000, 6'b000101, 16'h0);
    add(6'b110000, 6'b110001, AA);
    add(6'b110000, 6'b110001, AA);
    add(6'b110000, 6'b110001, AA);
    add(6'b110000, 6'b100101, AA);
    add(6'b110010, 6'b101101, AA);
    add(6'b110001, 6'b110101, AA);
    add(6'b110000, 6'b110001, AA);
    add(6'b000000, 6'b000101, AA);
    add(6'b000010, 6'b000101, 16'h0);
    add(6'b000010, 6'b000101, 16'h0);
    add(6'b000010, 6'b000101, 16'h0);
    // Stray acks are dropped and never make the counter wrap.
    add(6'b000010, 6'b000101, 16'h0);
    add(6'b100000, 6'b000101, 16'h0);
    add(6'b100010, 6'b100001, AA);
    add(6'b000000, 6'b000001, AA);
    add(6'b100000, 6'b000101, 16'h0);
    add(6'b100000, 6'b100001, AA);
    add(6'b000000, 6'b000001, AA);
    add(6'b000000, 6'b000101, 16'h0);

    #3;
    check("reset ctl/resp", {26'd0, outs()}, 32'b000101);
    check("reset err", {30'd0, o_a_err, o_b_err}, 32'd0);
    check("reset addr", {16'd0, o_addr}, 32'd0);
    check("reset data", o_data, 32'd0);
    check("reset sel/we", {27'd0, o_sel, o_we}, 32'd0);
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge i_clk);
      {i_a_cyc, i_a_stb, i_b_cyc, i_b_stb, i_ack, i_stall} = vecs[i].in;
      #3;
      tests++;
      if (outs() !== vecs[i].exp || o_addr !== vecs[i].addr) begin
        fails++;
        $display("FAIL vec %0d: outputs %b addr %h, expected %b addr %h",
                 i, outs(), o_addr, vecs[i].exp, vecs[i].addr);
      end
    end

    // Tie with A last granted -> B wins; check the B data path.
    @(negedge i_clk);
    {i_a_cyc, i_a_stb, i_b_cyc, i_b_stb, i_ack, i_stall} = 6'b101100;
    @(negedge i_clk);
    #3;
    check("B mux we/sel", {27'd0, o_we, o_sel}, {27'd0, 1'b1, 4'h3});
    check("B mux data", o_data, 32'hCAFE_F00D);
    check("rdata pass", o_rdata, 32'hDEAD_BEEF);
    check("B grant ctl", {26'd0, outs()}, 32'b110100);
    @(negedge i_clk);
    i_b_stb = 1'b0;
    i_rdata = 32'h0BAD_F00D;
    #2;
    i_reset_n = 1'b0;
    #1;
    check("async rst ctl", {26'd0, outs()}, 32'b000101);
    check("async rst data", o_data, 32'd0);
    check("rdata pass 2", o_rdata, 32'h0BAD_F00D);
    @(negedge i_clk);
    {i_a_cyc, i_a_stb, i_b_cyc, i_b_stb, i_ack, i_stall} = 6'b001010;
    i_reset_n = 1'b1;
    #3;
    check("post rst idle", {26'd0, outs()}, 32'b000101);
    @(negedge i_clk);
    #3;
    check("post rst stray ack", {26'd0, outs()}, 32'b100100);
    check("err outputs", {30'd0, o_a_err, o_b_err}, 32'd0);
    @(negedge i_clk);
    {i_a_cyc, i_a_stb, i_b_cyc, i_b_stb, i_ack, i_stall} = 6'b000000;
    @(negedge i_clk);
    #3;
    check("final idle", {26'd0, outs()}, 32'b000101);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
